// File: rtl/enemy_shot_controller_pkg.sv
// enemy_shot_controller_pkg: game constants shared by the enemy-shot controller, engine and renderer.
// The constants are the grid geometry, the sprite sizes, the screen limits, the NO_SHOT_ID encoding and the controller state encoding.
package enemy_shot_controller_pkg;
  localparam int N_ENEMIES = 24;
  localparam int COLS      = 8;
  localparam int SPACING_X = 48;
  localparam int SPACING_Y = 40;
  localparam int ENEMY_W   = 32;
  localparam int ENEMY_H   = 24;
  localparam int SHOT_W    = 4;
  localparam int SHOT_H    = 8;
  localparam int SHOT_DY   = 4;
  localparam int SCREEN_H  = 480;
  localparam int PLAYER_Y  = 440;
  localparam int PLAYER_W  = 32;
  localparam int PLAYER_H  = 16;
  localparam logic [5:0] NO_SHOT_ID = 6'(N_ENEMIES);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FLY  = 2'd1;
  localparam logic [1:0] ST_DEAD = 2'd2;
  typedef enum logic [1:0] {IDLE = ST_IDLE, FLY = ST_FLY, DEAD = ST_DEAD} state_t;
endpackage

// File: rtl/enemy_shot_controller_if.sv
// enemy_shot_controller_if: engine/renderer <-> enemy-shot controller signal bundle.
// Engine side (master) drives shooter_id, enemy_vivos, formation_x/y and player_x.
// Controller side (slave) drives shot_active, shot_x/y, shot_accepted and jogador_vivo.
interface enemy_shot_controller_if;
  import enemy_shot_controller_pkg::*;
  logic [5:0]           shooter_id;
  logic [N_ENEMIES-1:0] enemy_vivos;
  logic [9:0]           formation_x;
  logic [9:0]           formation_y;
  logic [9:0]           player_x;
  logic                 shot_active;
  logic [9:0]           shot_x;
  logic [9:0]           shot_y;
  logic                 shot_accepted;
  logic                 jogador_vivo;
  modport master (
    output shooter_id, enemy_vivos, formation_x, formation_y, player_x,
    input  shot_active, shot_x, shot_y, shot_accepted, jogador_vivo
  );
  modport slave (
    input  shooter_id, enemy_vivos, formation_x, formation_y, player_x,
    output shot_active, shot_x, shot_y, shot_accepted, jogador_vivo
  );
endinterface

// File: rtl/enemy_slot_pos.sv
// enemy_slot_pos: combinational decoder from an enemy id to the top-left corner of its grid slot.
// Ports: id_i is the enemy id, origin_x_i/origin_y_i is the formation origin,
// and x_o/y_o is the slot corner as an 11-bit value so that callers can add offsets before truncating.
module enemy_slot_pos
  import enemy_shot_controller_pkg::*;
(
  input  logic [5:0]  id_i,
  input  logic [9:0]  origin_x_i,
  input  logic [9:0]  origin_y_i,
  output logic [10:0] x_o,
  output logic [10:0] y_o
);
  logic [5:0] row, col;
  assign row = id_i / 6'(COLS);
  assign col = id_i % 6'(COLS);
  assign x_o = 11'(origin_x_i) + 11'(col) * 11'(SPACING_X);
  assign y_o = 11'(origin_y_i) + 11'(row) * 11'(SPACING_Y);
endmodule

// File: rtl/enemy_shot_controller.sv
// enemy_shot_controller: spawns one enemy projectile per fire request, steps it downward and detects a hit on the player.
// Ports: clk is the clock, reset_i is a synchronous active-low reset, and restart_i is a synchronous active-high restart with the same effect.
// bus is the slave side of enemy_shot_controller_if, which carries the engine inputs and the shot/player outputs.
module enemy_shot_controller
  import enemy_shot_controller_pkg::*;
#(
  parameter int STEP_DIV = 250000
) (
  input logic clk,
  input logic reset_i,
  input logic restart_i,
  enemy_shot_controller_if.slave bus
);
  localparam int CW = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    prev_q;
  logic [9:0]    x_q, x_d, y_q, y_d;
  logic          active_q, active_d, acc_q, acc_d, alive_q, alive_d;
  logic [10:0]   slot_x, slot_y, sx, sy, px;
  logic          req, fire, hit, tick, exit_bottom;
  enemy_slot_pos u_slot (
    .id_i       (bus.shooter_id),
    .origin_x_i (bus.formation_x),
    .origin_y_i (bus.formation_y),
    .x_o        (slot_x),
    .y_o        (slot_y)
  );
  // A held id gives one request, because only a change of id counts as a new request.
  assign req  = bus.shooter_id < NO_SHOT_ID && bus.shooter_id != prev_q;
  assign fire = req && bus.enemy_vivos[bus.shooter_id[4:0]];
  assign sx   = 11'(x_q);
  assign sy   = 11'(y_q);
  assign px   = 11'(bus.player_x);
  assign hit  = sx < px + 11'(PLAYER_W) && sx + 11'(SHOT_W) > px &&
                sy < 11'(PLAYER_Y + PLAYER_H) && sy + 11'(SHOT_H) > 11'(PLAYER_Y);
  assign tick = cnt_q == CW'(STEP_DIV - 1);
  assign exit_bottom = sy + 11'(SHOT_DY + SHOT_H) > 11'(SCREEN_H);
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    y_d      = y_q;
    active_d = active_q;
    acc_d    = 1'b0;
    alive_d  = alive_q;
    unique case (state_q)
      IDLE: if (fire) begin
        x_d      = 10'(slot_x + 11'(ENEMY_W / 2 - SHOT_W / 2));
        y_d      = 10'(slot_y + 11'(ENEMY_H));
        active_d = 1'b1;
        acc_d    = 1'b1;
        cnt_d    = '0;
        state_d  = FLY;
      end
      FLY: if (hit) begin
        active_d = 1'b0;
        alive_d  = 1'b0;
        state_d  = DEAD;
      end else if (tick) begin
        cnt_d    = '0;
        y_d      = exit_bottom ? y_q : y_q + 10'(SHOT_DY);
        active_d = !exit_bottom;
        state_d  = exit_bottom ? IDLE : FLY;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      default: begin
        active_d = 1'b0;
        alive_d  = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_i || restart_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      prev_q   <= NO_SHOT_ID;
      x_q      <= '0;
      y_q      <= '0;
      active_q <= 1'b0;
      acc_q    <= 1'b0;
      alive_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prev_q   <= bus.shooter_id;
      x_q      <= x_d;
      y_q      <= y_d;
      active_q <= active_d;
      acc_q    <= acc_d;
      alive_q  <= alive_d;
    end
  end
  assign bus.shot_active   = active_q;
  assign bus.shot_x        = x_q;
  assign bus.shot_y        = y_q;
  assign bus.shot_accepted = acc_q;
  assign bus.jogador_vivo  = alive_q;
endmodule

// File: tb/tb_enemy_shot_controller.sv
// tb_enemy_shot_controller: directed, table-driven bench for enemy_shot_controller with STEP_DIV=4.
module tb_enemy_shot_controller;
  logic clk = 1'b0;
  logic reset_i = 1'b0;
  logic restart_i = 1'b0;
  int pass_n = 0;
  int total_n = 0;
  enemy_shot_controller_if bus();
  enemy_shot_controller #(.STEP_DIV(4)) dut (
    .clk       (clk),
    .reset_i   (reset_i),
    .restart_i (restart_i),
    .bus       (bus)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [5:0]  id;
    logic [23:0] viv;
    logic        acc;
    logic        act;
    logic [9:0]  x;
    logic [9:0]  y;
  } vec_t;
  vec_t v[10];
  localparam logic [23:0] ALL = 24'hFF_FFFF;
  localparam logic [23:0] NO5 = 24'hFF_FFDF;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total_n++;
    if (got === exp) pass_n++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_y(input logic [9:0] target);
    int n = 0;
    while (bus.shot_y !== target && n < 3000) begin
      step();
      n++;
    end
    total_n++;
    if (bus.shot_y === target) pass_n++;
    else $display("FAIL wait_y: shot_y %0d never reached %0d", bus.shot_y, target);
  endtask
  task automatic chk_state(input string nm, input logic act, input logic alive, input logic [9:0] x, input logic [9:0] y);
    chk({nm, ".active"}, 32'(bus.shot_active), 32'(act));
    chk({nm, ".alive"}, 32'(bus.jogador_vivo), 32'(alive));
    chk({nm, ".x"}, 32'(bus.shot_x), 32'(x));
    chk({nm, ".y"}, 32'(bus.shot_y), 32'(y));
  endtask
  initial begin
    v[0] = '{6'd24, ALL, 1'b0, 1'b0, 10'd0,   10'd0};
    v[1] = '{6'd5,  NO5, 1'b0, 1'b0, 10'd0,   10'd0};
    v[2] = '{6'd30, ALL, 1'b0, 1'b0, 10'd0,   10'd0};
    v[3] = '{6'd24, ALL, 1'b0, 1'b0, 10'd0,   10'd0};
    v[4] = '{6'd10, ALL, 1'b1, 1'b1, 10'd126, 10'd96};
    v[5] = '{6'd10, ALL, 1'b0, 1'b1, 10'd126, 10'd96};
    v[6] = '{6'd24, ALL, 1'b0, 1'b1, 10'd126, 10'd96};
    v[7] = '{6'd3,  ALL, 1'b0, 1'b1, 10'd126, 10'd96};
    v[8] = '{6'd7,  ALL, 1'b0, 1'b1, 10'd126, 10'd100};
    v[9] = '{6'd24, ALL, 1'b0, 1'b1, 10'd126, 10'd100};
    bus.shooter_id  = 6'd24;
    bus.enemy_vivos = ALL;
    bus.formation_x = 10'd16;
    bus.formation_y = 10'd32;
    bus.player_x    = 10'd600;
    step();
    step();
    reset_i = 1'b1;
    chk_state("reset", 1'b0, 1'b1, 10'd0, 10'd0);
    chk("reset.acc", 32'(bus.shot_accepted), 32'd0);
    for (int i = 0; i < 10; i++) begin
      bus.shooter_id  = v[i].id;
      bus.enemy_vivos = v[i].viv;
      step();
      chk($sformatf("vec%0d.acc", i), 32'(bus.shot_accepted), 32'(v[i].acc));
      chk_state($sformatf("vec%0d", i), v[i].act, 1'b1, v[i].x, v[i].y);
    end
    wait_y(10'd472);
    chk_state("bottom.last", 1'b1, 1'b1, 10'd126, 10'd472);
    repeat (3) step();
    chk("bottom.pre", 32'(bus.shot_active), 32'd1);
    step();
    chk_state("bottom.exit", 1'b0, 1'b1, 10'd126, 10'd472);
    bus.shooter_id = 6'd0;
    step();
    chk("respawn.acc", 32'(bus.shot_accepted), 32'd1);
    chk_state("respawn", 1'b1, 1'b1, 10'd30, 10'd56);
    bus.shooter_id = 6'd24;
    step();
    restart_i = 1'b1;
    step();
    restart_i = 1'b0;
    chk_state("restart", 1'b0, 1'b1, 10'd0, 10'd0);
    bus.player_x   = 10'd120;
    bus.shooter_id = 6'd10;
    step();
    chk("hit.spawn.acc", 32'(bus.shot_accepted), 32'd1);
    chk_state("hit.spawn", 1'b1, 1'b1, 10'd126, 10'd96);
    bus.shooter_id = 6'd24;
    wait_y(10'd436);
    chk_state("hit.pre", 1'b1, 1'b1, 10'd126, 10'd436);
    step();
    chk_state("hit", 1'b0, 1'b0, 10'd126, 10'd436);
    bus.shooter_id = 6'd3;
    step();
    chk("dead.acc", 32'(bus.shot_accepted), 32'd0);
    chk_state("dead", 1'b0, 1'b0, 10'd126, 10'd436);
    bus.shooter_id = 6'd24;
    reset_i = 1'b0;
    step();
    reset_i = 1'b1;
    chk_state("dead.reset", 1'b0, 1'b1, 10'd0, 10'd0);
    bus.shooter_id = 6'd0;
    step();
    chk("final.acc", 32'(bus.shot_accepted), 32'd1);
    chk_state("final", 1'b1, 1'b1, 10'd30, 10'd56);
    step();
    chk("final.pulse", 32'(bus.shot_accepted), 32'd0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
